// File: rtl/pwm_seq_pkg.sv
// -----------------------------------------------------------------------------
// pwm_seq_pkg
// Shared definitions for the PWM ramp sequencer slice: default widths, the
// sequencer state type and the ramp direction encoding.
// -----------------------------------------------------------------------------
package pwm_seq_pkg;

  localparam int DUTY_W_DEF = 8;
  localparam int DIV_W_DEF  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/pwm_seq_tick.sv
// -----------------------------------------------------------------------------
// pwm_seq_tick
// Step-interval counter. While enabled it counts clocks and raises o_tick for
// one cycle every i_interval clocks. Once o_tick has been raised, the counter
// restarts from zero.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   i_en       count enable (ramp actively stepping)
//   i_clear    restart the interval from zero (new ramp accepted)
//   i_interval clocks per tick; the caller guarantees a value of at least 1
//   o_tick     one-cycle pulse marking the edge at which a step is applied
// -----------------------------------------------------------------------------
module pwm_seq_tick
  import pwm_seq_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clear,
  input  logic [DIV_W-1:0] i_interval,
  output logic             o_tick
);

  localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] r_count;
  logic             w_wrap;

  // The last count of an interval is interval-1, so a tick lands exactly
  // `interval` clocks after the previous clear or tick.
  assign w_wrap = (r_count == (i_interval - DIV_ONE));
  assign o_tick = i_en & w_wrap;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      if (w_wrap) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + DIV_ONE;
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// pwm_ramp_sequencer
// Fade/ramp controller that drives the PWM peripheral duty-cycle input. After
// a valid/ready config handshake, it moves the duty from the start value toward
// the end value. Each move is one fixed step, and moves occur once every
// programmable number of clocks. At the end it either stops (one-shot) or
// bounces between start and end forever (loop) until aborted.
//
// Ports:
//   clk            system clock
//   rst            synchronous reset, active-high
//   i_cfg_valid    config offered
//   o_cfg_ready    config can be accepted (idle and not in reset)
//   i_cfg_start    first duty value
//   i_cfg_end      target duty value
//   i_cfg_step     increment per step (0 behaves as 1)
//   i_cfg_interval clocks between steps (0 behaves as 1)
//   i_cfg_loop     1 = ping-pong forever, 0 = one-shot
//   i_abort        stop the ramp and hold the current duty; also blocks accept
//   o_duty_cycle   current duty to the PWM peripheral
//   o_duty_update  one-cycle pulse when o_duty_cycle is written
//   o_busy         ramp in progress
//   o_done         one-cycle pulse when a one-shot ramp completes
// -----------------------------------------------------------------------------
module pwm_ramp_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [DUTY_W-1:0] i_cfg_start,
  input  logic [DUTY_W-1:0] i_cfg_end,
  input  logic [DUTY_W-1:0] i_cfg_step,
  input  logic [DIV_W-1:0]  i_cfg_interval,
  input  logic              i_cfg_loop,
  input  logic              i_abort,
  output logic [DUTY_W-1:0] o_duty_cycle,
  output logic              o_duty_update,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [DUTY_W-1:0] DUTY_ONE = {{(DUTY_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0]  DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  logic [DUTY_W-1:0] r_duty;
  logic              r_update;
  logic              r_done;
  logic [DUTY_W-1:0] r_start;
  logic [DUTY_W-1:0] r_end;
  logic [DUTY_W-1:0] r_target;
  logic [DUTY_W-1:0] r_step;
  logic [DIV_W-1:0]  r_interval;
  logic              r_dir;
  logic              r_loop;
  logic              r_hold;
  logic              r_last;

  logic              w_accept;
  logic              w_cfg_flat;
  logic [DUTY_W-1:0] w_cfg_step;
  logic [DIV_W-1:0]  w_cfg_interval;
  logic              w_tick_en;
  logic              w_tick;
  logic [DUTY_W:0]   w_sum;
  logic [DUTY_W:0]   w_diff;
  logic [DUTY_W-1:0] w_next;

  assign o_cfg_ready   = (r_state == ST_IDLE) & ~rst;
  assign o_busy        = (r_state == ST_RUN);
  assign o_duty_cycle  = r_duty;
  assign o_duty_update = r_update;
  assign o_done        = r_done;

  assign w_accept       = i_cfg_valid & o_cfg_ready & ~i_abort;
  assign w_cfg_flat     = (i_cfg_start == i_cfg_end);
  assign w_cfg_step     = (i_cfg_step == '0) ? DUTY_ONE : i_cfg_step;
  assign w_cfg_interval = (i_cfg_interval == '0) ? DIV_ONE : i_cfg_interval;

  // Stepping pauses in two cases. A flat loop ramp holds its duty and never
  // steps. In the cycle after the final one-shot step, only the completion is
  // reported, so no further step is taken.
  assign w_tick_en = (r_state == ST_RUN) & ~r_hold & ~r_last;

  pwm_seq_tick #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .i_en      (w_tick_en),
    .i_clear   (w_accept),
    .i_interval(r_interval),
    .o_tick    (w_tick)
  );

  // Saturating step using one extra bit, so that neither duty+step nor
  // duty-target can wrap. Once the step would reach or pass the target, the
  // result is clamped to the target.
  assign w_sum  = {1'b0, r_duty} + {1'b0, r_step};
  assign w_diff = {1'b0, r_duty} - {1'b0, r_target};

  always_comb begin
    w_next = r_duty;
    if (r_dir == DIR_UP) begin
      if (w_sum >= {1'b0, r_target}) begin
        w_next = r_target;
      end else begin
        w_next = w_sum[DUTY_W-1:0];
      end
    end else begin
      if (w_diff <= {1'b0, r_step}) begin
        w_next = r_target;
      end else begin
        w_next = r_duty - r_step;
      end
    end
  end

  // Sequencer FSM. A one-shot ramp with start==end completes immediately.
  // In that case only done is pulsed; no duty_update is pulsed, because the
  // two pulses must never coincide. After the final one-shot step, one extra
  // RUN cycle (r_last) separates the last duty_update from done. In abort
  // handling, abort wins over both stepping and completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_duty     <= '0;
      r_update   <= 1'b0;
      r_done     <= 1'b0;
      r_start    <= '0;
      r_end      <= '0;
      r_target   <= '0;
      r_step     <= DUTY_ONE;
      r_interval <= DIV_ONE;
      r_dir      <= DIR_UP;
      r_loop     <= 1'b0;
      r_hold     <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      r_update <= 1'b0;
      r_done   <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          r_start    <= i_cfg_start;
          r_end      <= i_cfg_end;
          r_target   <= i_cfg_end;
          r_step     <= w_cfg_step;
          r_interval <= w_cfg_interval;
          r_dir      <= (i_cfg_end >= i_cfg_start) ? DIR_UP : DIR_DOWN;
          r_loop     <= i_cfg_loop;
          r_duty     <= i_cfg_start;
          r_hold     <= w_cfg_flat;
          r_last     <= 1'b0;
          if (w_cfg_flat && !i_cfg_loop) begin
            r_done <= 1'b1;
          end else begin
            r_state  <= ST_RUN;
            r_update <= 1'b1;
          end
        end
      end else begin
        if (i_abort) begin
          r_state <= ST_IDLE;
          r_last  <= 1'b0;
        end else if (r_last) begin
          r_state <= ST_IDLE;
          r_last  <= 1'b0;
          r_done  <= 1'b1;
        end else if (w_tick) begin
          r_duty   <= w_next;
          r_update <= 1'b1;
          if (w_next == r_target) begin
            if (r_loop) begin
              r_target <= (r_target == r_end) ? r_start : r_end;
              r_dir    <= ~r_dir;
            end else begin
              r_last <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
